// File: rtl/fpu_flt2int_pkg.sv
// Shared definitions for the float-to-integer converter: opcodes, rounding
// modes, widths, FSM state type and the saturation helper.
package fpu_flt2int_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned FUNC_W = 5;
   localparam int unsigned RM_W   = 3;

   localparam logic [FUNC_W-1:0] ALU_FCVTWS  = 5'h18;
   localparam logic [FUNC_W-1:0] ALU_FCVTWUS = 5'h19;

   localparam logic [RM_W-1:0] RNE = 3'b000;
   localparam logic [RM_W-1:0] RTZ = 3'b001;
   localparam logic [RM_W-1:0] RDN = 3'b010;
   localparam logic [RM_W-1:0] RUP = 3'b011;
   localparam logic [RM_W-1:0] RMM = 3'b100;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      F2I_IDLE,
      F2I_SHIFT,
      F2I_ROUND,
      F2I_DONE
   } f2i_state_t;

   // Result for NaN, infinities and out-of-range magnitudes.
   function automatic logic [XLEN-1:0] f2i_sat(input logic sgn, input logic uns, input logic nan);
      if (nan || !sgn) return uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      return uns ? 32'h0000_0000 : 32'h8000_0000;
   endfunction

endpackage

// File: rtl/fpu_flt2int_if.sv
// Request/response bundle between the EX stage and the float-to-integer unit.
interface fpu_flt2int_if;
   import fpu_flt2int_pkg::*;

   logic              start;
   logic [XLEN-1:0]   opa;
   logic [FUNC_W-1:0] ID_EX_alu_func;
   logic [RM_W-1:0]   flt_rm;
   logic [XLEN-1:0]   fpu_res;
   logic              fpu_busy;
   logic              fpu_done;

   modport master (output start, opa, ID_EX_alu_func, flt_rm,
                   input  fpu_res, fpu_busy, fpu_done);
   modport slave  (input  start, opa, ID_EX_alu_func, flt_rm,
                   output fpu_res, fpu_busy, fpu_done);
endinterface

// File: rtl/flt_round_inc.sv
// Round-increment decision from rounding mode, sign, LSB, round and sticky bits.
module flt_round_inc
   import fpu_flt2int_pkg::*;
(
   input  logic [RM_W-1:0] rm,
   input  logic            sgn,
   input  logic            lsb,
   input  logic            r_bit,
   input  logic            s_bit,
   output logic            inc
);

   // Reserved encodings fall back to round-to-nearest-even.
   always_comb begin
      inc = 1'b0;
      case (rm)
         RTZ:     inc = 1'b0;
         RDN:     inc = sgn & (r_bit | s_bit);
         RUP:     inc = !sgn & (r_bit | s_bit);
         RMM:     inc = r_bit;
         default: inc = r_bit & (s_bit | lsb);
      endcase
   end

endmodule

// File: rtl/fpu_flt2int.sv
// Iterative FCVT.W.S / FCVT.WU.S: one-bit-per-cycle significand alignment,
// mode-dependent rounding and RISC-V saturation.
module fpu_flt2int
   import fpu_flt2int_pkg::*;
(
   input logic          clk,
   input logic          rst,
   fpu_flt2int_if.slave bus
);

   f2i_state_t        state_q, state_d;
   logic [XLEN-1:0]   mag_q, mag_d;
   logic              r_q, r_d, s_q, s_d;
   logic              sgn_q, sgn_d, uns_q, uns_d, left_q, left_d;
   logic [RM_W-1:0]   rm_q, rm_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              busy_q, busy_d, done_q, done_d;

   logic [EXP_W-1:0]  op_exp;
   logic [MANT_W-1:0] op_mant;
   logic              is_nan, is_big, is_tiny, shift_left;
   logic [CNT_W-1:0]  shift_n;
   logic              inc;
   logic [XLEN:0]     rmag;
   logic [XLEN-1:0]   round_res;

   assign op_exp  = bus.opa[30:23];
   assign op_mant = bus.opa[22:0];

   // Unbiased exponent e: big means e >= 32, tiny means e < -1; n = |e - 23|.
   always_comb begin
      is_nan     = (op_exp == 8'hFF) && (op_mant != '0);
      is_big     = op_exp >= 8'd159;
      is_tiny    = op_exp < 8'd126;
      shift_left = op_exp > 8'd150;
      shift_n    = (op_exp >= 8'd150) ? CNT_W'(op_exp - 8'd150) : CNT_W'(8'd150 - op_exp);
   end

   flt_round_inc u_round_inc (
      .rm    (rm_q),
      .sgn   (sgn_q),
      .lsb   (mag_q[0]),
      .r_bit (r_q),
      .s_bit (s_q),
      .inc   (inc)
   );

   // Rounded magnitude kept at 33 bits so unsigned overflow is visible.
   always_comb begin
      rmag = {1'b0, mag_q} + (XLEN+1)'(inc);
      if (uns_q) begin
         if (sgn_q)        round_res = '0;
         else if (rmag[XLEN]) round_res = '1;
         else              round_res = rmag[XLEN-1:0];
      end else if (!sgn_q && rmag > 33'h0_7FFF_FFFF) begin
         round_res = 32'h7FFF_FFFF;
      end else if (sgn_q && rmag > 33'h0_8000_0000) begin
         round_res = 32'h8000_0000;
      end else begin
         round_res = sgn_q ? (32'd0 - rmag[XLEN-1:0]) : rmag[XLEN-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      r_d     = r_q;
      s_d     = s_q;
      sgn_d   = sgn_q;
      uns_d   = uns_q;
      left_d  = left_q;
      rm_d    = rm_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         F2I_IDLE: begin
            if (bus.start) begin
               sgn_d  = bus.opa[31];
               uns_d  = (bus.ID_EX_alu_func == ALU_FCVTWUS);
               rm_d   = bus.flt_rm;
               left_d = shift_left;
               cnt_d  = shift_n;
               mag_d  = {8'b0, 1'b1, op_mant};
               r_d    = FALSE;
               s_d    = FALSE;
               if (is_big) begin
                  res_d   = f2i_sat(bus.opa[31], bus.ID_EX_alu_func == ALU_FCVTWUS, is_nan);
                  state_d = F2I_DONE;
               end else if (is_tiny) begin
                  mag_d   = '0;
                  s_d     = |bus.opa[30:0];
                  state_d = F2I_ROUND;
               end else begin
                  state_d = (shift_n != '0) ? F2I_SHIFT : F2I_ROUND;
               end
            end
         end
         F2I_SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               s_d   = s_q | r_q;
               r_d   = mag_q[0];
               mag_d = mag_q >> 1;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = F2I_ROUND;
         end
         F2I_ROUND: begin
            res_d   = round_res;
            state_d = F2I_DONE;
         end
         default: state_d = F2I_IDLE;
      endcase
      busy_d = (state_d == F2I_SHIFT) || (state_d == F2I_ROUND);
      done_d = (state_d == F2I_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F2I_IDLE;
         mag_q   <= '0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
         sgn_q   <= 1'b0;
         uns_q   <= 1'b0;
         left_q  <= 1'b0;
         rm_q    <= RNE;
         cnt_q   <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         r_q     <= r_d;
         s_q     <= s_d;
         sgn_q   <= sgn_d;
         uns_q   <= uns_d;
         left_q  <= left_d;
         rm_q    <= rm_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.fpu_res  = res_q;
   assign bus.fpu_busy = busy_q;
   assign bus.fpu_done = done_q;

endmodule

// File: tb/tb_fpu_flt2int.sv
// Scoreboard bench for fpu_flt2int: directed conversions, timing of done/busy,
// ignored start pulses and reset abort.
module tb_fpu_flt2int;
   import fpu_flt2int_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] res;
      int          t;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   fpu_flt2int_if bus ();

   fpu_flt2int dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: busy window and result/latency of every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0)
         chk({sb[0].name, " busy"}, 32'(bus.fpu_busy),
             32'((cyc > sb[0].t) && (cyc < sb[0].done_cyc)));
      if (bus.fpu_done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected done", 32'(bus.fpu_done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.name, " res"}, bus.fpu_res, e.res);
            chk({e.name, " done cycle"}, 32'(cyc), 32'(e.done_cyc));
         end
      end
   end

   task automatic issue(input string name, input logic [31:0] a, input logic uns,
                        input logic [2:0] rm, input logic [31:0] r, input int lat,
                        input bit pulse);
      exp_t e;
      bit   got;
      @(negedge clk);
      bus.start          = 1'b1;
      bus.opa            = a;
      bus.ID_EX_alu_func = uns ? ALU_FCVTWUS : ALU_FCVTWS;
      bus.flt_rm         = rm;
      e.name     = name;
      e.res      = r;
      e.t        = cyc;
      e.done_cyc = cyc + lat;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      sb.push_back(e);
      if (pulse) begin
         repeat (2) @(negedge clk);
         bus.start = 1'b1;
         bus.opa   = 32'h4F80_0000;
         bus.flt_rm = RUP;
         repeat (3) @(negedge clk);
         bus.start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.fpu_done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: no done within 40 cycles", name);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      bus.start          = 1'b0;
      bus.opa            = '0;
      bus.ID_EX_alu_func = ALU_FCVTWS;
      bus.flt_rm         = RNE;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset res", bus.fpu_res, 32'h0);
      chk("reset busy", 32'(bus.fpu_busy), 32'd0);
      chk("reset done", 32'(bus.fpu_done), 32'd0);

      issue("1.0 W RNE",      32'h3F80_0000, 1'b0, RNE, 32'h0000_0001, 25, 1'b0);
      issue("2.5 W RNE",      32'h4020_0000, 1'b0, RNE, 32'h0000_0002, 24, 1'b0);
      issue("2.5 W RMM",      32'h4020_0000, 1'b0, RMM, 32'h0000_0003, 24, 1'b0);
      issue("2.5 W RUP",      32'h4020_0000, 1'b0, RUP, 32'h0000_0003, 24, 1'b0);
      issue("2.5 W RTZ",      32'h4020_0000, 1'b0, RTZ, 32'h0000_0002, 24, 1'b0);
      issue("-2.5 W RDN",     32'hC020_0000, 1'b0, RDN, 32'hFFFF_FFFD, 24, 1'b0);
      issue("-2.5 W RNE",     32'hC020_0000, 1'b0, RNE, 32'hFFFF_FFFE, 24, 1'b0);
      issue("0.5 W RNE",      32'h3F00_0000, 1'b0, RNE, 32'h0000_0000, 26, 1'b0);
      issue("0.5 W RUP",      32'h3F00_0000, 1'b0, RUP, 32'h0000_0001, 26, 1'b0);
      issue("2^31 W",         32'h4F00_0000, 1'b0, RNE, 32'h7FFF_FFFF, 10, 1'b0);
      issue("2^31 WU",        32'h4F00_0000, 1'b1, RNE, 32'h8000_0000, 10, 1'b0);
      issue("-2^31 W",        32'hCF00_0000, 1'b0, RNE, 32'h8000_0000, 10, 1'b0);
      issue("max<2^31 W",     32'h4EFF_FFFF, 1'b0, RNE, 32'h7FFF_FF80, 9,  1'b0);
      issue("2^32 W",         32'h4F80_0000, 1'b0, RNE, 32'h7FFF_FFFF, 1,  1'b0);
      issue("2^32 WU",        32'h4F80_0000, 1'b1, RNE, 32'hFFFF_FFFF, 1,  1'b0);
      issue("NaN W",          32'h7FC0_0000, 1'b0, RNE, 32'h7FFF_FFFF, 1,  1'b0);
      issue("NaN WU",         32'h7FC0_0000, 1'b1, RNE, 32'hFFFF_FFFF, 1,  1'b0);
      issue("-inf W",         32'hFF80_0000, 1'b0, RNE, 32'h8000_0000, 1,  1'b0);
      issue("-inf WU",        32'hFF80_0000, 1'b1, RNE, 32'h0000_0000, 1,  1'b0);
      issue("+inf W",         32'h7F80_0000, 1'b0, RTZ, 32'h7FFF_FFFF, 1,  1'b0);
      issue("denorm W RUP",   32'h0000_0001, 1'b0, RUP, 32'h0000_0001, 2,  1'b0);
      issue("denorm W RTZ",   32'h0000_0001, 1'b0, RTZ, 32'h0000_0000, 2,  1'b0);
      issue("-0.3 W RDN",     32'hBE99_999A, 1'b0, RDN, 32'hFFFF_FFFF, 2,  1'b0);
      issue("-0.3 WU RDN",    32'hBE99_999A, 1'b1, RDN, 32'h0000_0000, 2,  1'b0);
      issue("-1.0 WU RNE",    32'hBF80_0000, 1'b1, RNE, 32'h0000_0000, 25, 1'b0);
      issue("100.0 WU rm=7",  32'h42C8_0000, 1'b1, 3'b111, 32'h0000_0064, 19, 1'b0);
      issue("2.5 ignore start", 32'h4020_0000, 1'b0, RNE, 32'h0000_0002, 24, 1'b1);

      // Abort a 1.0 conversion with reset in cycle T+5.
      @(negedge clk);
      bus.start          = 1'b1;
      bus.opa            = 32'h3F80_0000;
      bus.ID_EX_alu_func = ALU_FCVTWS;
      bus.flt_rm         = RNE;
      t0 = cyc;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort cycle", 32'(cyc), 32'(t0 + 5));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(bus.fpu_busy), 32'd0);
      chk("abort res", bus.fpu_res, 32'h0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("abort no done", 32'(bus.fpu_done), 32'd0);
      end

      issue("1.0 after abort", 32'h3F80_0000, 1'b0, RNE, 32'h0000_0001, 25, 1'b0);
      repeat (3) @(posedge clk);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
